// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store alignment stage: func3 codes,
// FSM state encoding and the misalignment test used by the split logic.
// Pure declarations; no timing or flow-control behaviour of its own.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_HI = 2'd1,
    STORE_B = 2'd2
  } lsu_state_t;

  // Halfwords need an even address and words a 4-byte aligned one; byte
  // accesses and the unused width codes are never split.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (f3)
      F3_H, F3_HU: mis = off[0];
      F3_W:        mis = (off != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_extract.sv
// Reassembles a misaligned load from the {hi,lo} word pair: shift by byte offset, size, extend.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the result is meaningful only while the parent is in its second read.
module load_extract
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] pair,
  input  logic [1:0]        offset,
  input  logic [2:0]        func3,
  output logic [XLEN-1:0]   result
);

  logic [XLEN-1:0] shifted;

  // Bring the first requested byte down to bit 0, then trim and extend by width.
  always_comb begin
    shifted = XLEN'(pair >> {offset, 3'b000});
    result  = shifted;
    case (func3)
      F3_B:    result = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_H:    result = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_BU:   result = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_HU:   result = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_align_unit.sv
// Load/store alignment stage between EX/MEM and DataMem; splits misaligned accesses.
// Latency: aligned 0 cycles; misaligned load 2 cycles (1 stall); misaligned store N cycles (N-1 stalls).
// Backpressure: raises stall while a split needs more cycles; define MISALIGNED_TRAP_EN to trap instead of split.
module lsu_align_unit
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] data_in,
  input  logic            flush,
  output logic [XLEN-1:0] data_out,
  output logic            stall,
  output logic            misaligned_trap,
  output logic            dm_MemRead,
  output logic            dm_MemWrite,
  output logic [2:0]      dm_func3,
  output logic [XLEN-1:0] dm_addr,
  output logic [XLEN-1:0] dm_data_in,
  input  logic [XLEN-1:0] dm_data_out
);

  lsu_state_t      state_q, state_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [1:0]      cnt_q, cnt_d;

  logic            req_rd, req_wr, mis;
  logic [1:0]      last_idx;
  logic [XLEN-1:0] base;
  logic [XLEN-1:0] ext_res;

  // A simultaneous load and store is treated as a store.
  assign req_wr   = MemWrite;
  assign req_rd   = MemRead & ~MemWrite;
  assign mis      = (req_rd | req_wr) & is_misaligned(func3, addr[1:0]);
  assign last_idx = (func3 == F3_W) ? 2'd3 : 2'd1;
  assign base     = {addr[XLEN-1:2], 2'b00};

  load_extract #(.XLEN(XLEN)) u_extract (
    .pair   ({dm_data_out, lo_q}),
    .offset (addr[1:0]),
    .func3  (func3),
    .result (ext_res)
  );

  // Next-state and DataMem steering; outputs are forced to zero while in reset.
  always_comb begin
    state_d         = state_q;
    lo_d            = lo_q;
    cnt_d           = cnt_q;
    stall           = 1'b0;
    misaligned_trap = 1'b0;
    dm_MemRead      = 1'b0;
    dm_MemWrite     = 1'b0;
    dm_func3        = func3;
    dm_addr         = addr;
    dm_data_in      = data_in;
    data_out        = '0;

    case (state_q)
      IDLE: begin
        if (!mis) begin
          dm_MemRead  = req_rd;
          dm_MemWrite = req_wr;
          data_out    = dm_data_out;
        end else begin
`ifdef MISALIGNED_TRAP_EN
          misaligned_trap = 1'b1;
`else
          // A flushed request must not start a split or touch memory.
          if (!flush) begin
            stall = 1'b1;
            if (req_wr) begin
              dm_MemWrite = 1'b1;
              dm_func3    = F3_B;
              state_d     = STORE_B;
              cnt_d       = 2'd1;
            end else begin
              dm_MemRead = 1'b1;
              dm_func3   = F3_W;
              dm_addr    = base;
              lo_d       = dm_data_out;
              state_d    = LOAD_HI;
            end
          end
`endif
        end
      end

      LOAD_HI: begin
        dm_func3 = F3_W;
        dm_addr  = base + XLEN'(4);
        state_d  = IDLE;
        if (!flush) begin
          dm_MemRead = 1'b1;
          data_out   = ext_res;
        end
      end

      STORE_B: begin
        dm_func3   = F3_B;
        dm_addr    = addr + XLEN'(cnt_q);
        dm_data_in = data_in >> {cnt_q, 3'b000};
        if (flush) begin
          state_d = IDLE;
          cnt_d   = 2'd0;
        end else begin
          dm_MemWrite = 1'b1;
          if (cnt_q == last_idx) begin
            state_d = IDLE;
            cnt_d   = 2'd0;
          end else begin
            stall = 1'b1;
            cnt_d = cnt_q + 2'd1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
    endcase

    if (!rst_n) begin
      stall           = 1'b0;
      misaligned_trap = 1'b0;
      dm_MemRead      = 1'b0;
      dm_MemWrite     = 1'b0;
      dm_func3        = 3'b000;
      dm_addr         = '0;
      dm_data_in      = '0;
      data_out        = '0;
    end
  end

  // State, captured low word and byte counter; reset wins over flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lo_q    <= '0;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_lsu_align_unit.sv
// Bench for lsu_align_unit with a byte-addressed DataMem model.
// Expected load results go through a queue scoreboard; memory effects are checked by readback.
// MISALIGNED_TRAP_EN selects the trap scenario instead of the split scenarios.
module tb_lsu_align_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            MemRead, MemWrite, flush;
  logic [2:0]      func3;
  logic [XLEN-1:0] addr, data_in;
  logic [XLEN-1:0] data_out;
  logic            stall, misaligned_trap;
  logic            dm_MemRead, dm_MemWrite;
  logic [2:0]      dm_func3;
  logic [XLEN-1:0] dm_addr, dm_data_in, dm_data_out;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  lsu_align_unit #(.XLEN(XLEN)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .MemRead         (MemRead),
    .MemWrite        (MemWrite),
    .func3           (func3),
    .addr            (addr),
    .data_in         (data_in),
    .flush           (flush),
    .data_out        (data_out),
    .stall           (stall),
    .misaligned_trap (misaligned_trap),
    .dm_MemRead      (dm_MemRead),
    .dm_MemWrite     (dm_MemWrite),
    .dm_func3        (dm_func3),
    .dm_addr         (dm_addr),
    .dm_data_in      (dm_data_in),
    .dm_data_out     (dm_data_out)
  );

  // DataMem model: 64 bytes, combinational word read, writes on the rising edge.
  logic [7:0]  mem [0:63];
  logic        preload_req = 1'b0;
  logic [31:0] rd_addr[$];
  int          wr_n = 0;
  logic [5:0]  ra, wa;

  assign ra          = {dm_addr[5:2], 2'b00};
  assign wa          = dm_addr[5:0];
  assign dm_data_out = {mem[ra + 6'd3], mem[ra + 6'd2], mem[ra + 6'd1], mem[ra]};

  always @(posedge clk) begin
    if (preload_req) begin
      for (int k = 8; k < 64; k++) mem[k] <= 8'h00;
      mem[0] <= 8'hF4; mem[1] <= 8'h06; mem[2] <= 8'h01; mem[3] <= 8'h03;
      mem[4] <= 8'h34; mem[5] <= 8'hE6; mem[6] <= 8'h04; mem[7] <= 8'h00;
    end else if (dm_MemWrite) begin
      wr_n <= wr_n + 1;
      mem[wa] <= dm_data_in[7:0];
      if (dm_func3[1:0] != 2'b00) mem[wa + 6'd1] <= dm_data_in[15:8];
      if (dm_func3[1:0] == 2'b10) begin
        mem[wa + 6'd2] <= dm_data_in[23:16];
        mem[wa + 6'd3] <= dm_data_in[31:24];
      end
    end
    if (dm_MemRead) rd_addr.push_back(dm_addr);
  end

  task automatic preload();
    preload_req = 1'b1;
    @(posedge clk); #1;
    preload_req = 1'b0;
  endtask

  // Drives one request and holds it until stall drops; returns the
  // completion-cycle data_out and the number of stall cycles seen.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] dout, output int stalls);
    bit done;
    int cycles;
    MemRead = rd; MemWrite = wr; func3 = f3; addr = a; data_in = d;
    stalls = 0; cycles = 0; done = 1'b0; dout = '0;
    while (!done && cycles < 16) begin
      @(negedge clk);
      cycles++;
      if (stall === 1'b1) stalls++;
      else begin
        done = 1'b1;
        dout = data_out;
      end
      @(posedge clk); #1;
    end
    MemRead = 1'b0; MemWrite = 1'b0;
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL access_timeout addr=%h: stall still high after %0d cycles, required low", a, cycles);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0;
    MemRead = 1'b1; MemWrite = 1'b0; func3 = 3'b010; addr = 32'h0000_0005; data_in = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({stall, misaligned_trap, dm_MemRead, dm_MemWrite} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ctrl got stall/trap/rd/wr=%b required 0000", {stall, misaligned_trap, dm_MemRead, dm_MemWrite});
    end
    vectors++;
    if (data_out !== 32'h0) begin
      miscompares++; $display("FAIL reset_data_out got %h required 00000000", data_out);
    end
    vectors++;
    if ({dm_addr, dm_data_in, dm_func3} !== 67'h0) begin
      miscompares++;
      $display("FAIL reset_dm_bus got addr=%h din=%h f3=%b required all zero", dm_addr, dm_data_in, dm_func3);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; MemRead = 1'b0;
    preload();
  endtask

  task automatic test_aligned();
    logic [31:0] tab_a[3];
    logic [31:0] tab_e[3];
    logic [31:0] dout, e;
    int st;
    tab_a = '{32'h0, 32'h4, 32'h8};
    tab_e = '{32'h030106F4, 32'h0004E634, 32'h0};
    preload();
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(tab_e[k]);
      access(1'b1, 1'b0, 3'b010, tab_a[k], 32'h0, dout, st);
      e = exp_q.pop_front();
      vectors++;
      if (dout !== e || st != 0) begin
        miscompares++;
        $display("FAIL aligned_lw@%h got %h stalls=%0d required %h stalls=0", tab_a[k], dout, st, e);
      end
    end
    // Store-wins: both strobes high performs the store.
    access(1'b1, 1'b1, 3'b010, 32'h8, 32'h11223344, dout, st);
    exp_q.push_back(32'h11223344);
    access(1'b1, 1'b0, 3'b010, 32'h8, 32'h0, dout, st);
    e = exp_q.pop_front();
    vectors++;
    if (dout !== e) begin
      miscompares++; $display("FAIL store_wins got %h required %h", dout, e);
    end
    // Byte store is never split.
    access(1'b0, 1'b1, 3'b000, 32'h5, 32'hFFFF_FF80, dout, st);
    exp_q.push_back(32'h00048034);
    access(1'b1, 1'b0, 3'b010, 32'h4, 32'h0, dout, st);
    e = exp_q.pop_front();
    vectors++;
    if (dout !== e || st != 0) begin
      miscompares++; $display("FAIL byte_store got %h stalls=%0d required %h stalls=0", dout, st, e);
    end
  endtask

`ifndef MISALIGNED_TRAP_EN
  task automatic test_misaligned_load();
    logic [31:0] dout, e;
    int st, n0;
    preload();
    n0 = rd_addr.size();
    exp_q.push_back(32'h34030106);
    access(1'b1, 1'b0, 3'b010, 32'h1, 32'h0, dout, st);
    e = exp_q.pop_front();
    vectors++;
    if (dout !== e || st != 1) begin
      miscompares++; $display("FAIL lw@1 got %h stalls=%0d required %h stalls=1", dout, st, e);
    end
    vectors++;
    if (rd_addr.size() != n0 + 2 || rd_addr[n0] !== 32'h0 || rd_addr[n0+1] !== 32'h4) begin
      miscompares++; $display("FAIL lw@1_reads got %0d reads required 2 at 00000000,00000004", rd_addr.size() - n0);
    end
    // Back-to-back misaligned loads, including a halfword.
    exp_q.push_back(32'h04E63403);
    access(1'b1, 1'b0, 3'b010, 32'h3, 32'h0, dout, st);
    e = exp_q.pop_front();
    vectors++;
    if (dout !== e || st != 1) begin
      miscompares++; $display("FAIL lw@3 got %h stalls=%0d required %h stalls=1", dout, st, e);
    end
    exp_q.push_back(32'h00000106);
    access(1'b1, 1'b0, 3'b001, 32'h1, 32'h0, dout, st);
    e = exp_q.pop_front();
    vectors++;
    if (dout !== e || st != 1) begin
      miscompares++; $display("FAIL lh@1 got %h stalls=%0d required %h stalls=1", dout, st, e);
    end
  endtask

  task automatic test_misaligned_store();
    logic [31:0] dout, e;
    int st, w0;
    preload();
    w0 = wr_n;
    access(1'b0, 1'b1, 3'b001, 32'h3, 32'h0000F0AB, dout, st);
    vectors++;
    if (st != 1 || wr_n != w0 + 2) begin
      miscompares++; $display("FAIL sh@3 got stalls=%0d writes=%0d required stalls=1 writes=2", st, wr_n - w0);
    end
    exp_q.push_back(32'hFFFFF0AB);
    access(1'b1, 1'b0, 3'b001, 32'h3, 32'h0, dout, st);
    e = exp_q.pop_front();
    vectors++;
    if (dout !== e) begin
      miscompares++; $display("FAIL lh@3 got %h required %h", dout, e);
    end
    exp_q.push_back(32'h0000F0AB);
    access(1'b1, 1'b0, 3'b101, 32'h3, 32'h0, dout, st);
    e = exp_q.pop_front();
    vectors++;
    if (dout !== e) begin
      miscompares++; $display("FAIL lhu@3 got %h required %h", dout, e);
    end
    preload();
    w0 = wr_n;
    access(1'b0, 1'b1, 3'b010, 32'h6, 32'hDEADBEEF, dout, st);
    vectors++;
    if (st != 3 || wr_n != w0 + 4) begin
      miscompares++; $display("FAIL sw@6 got stalls=%0d writes=%0d required stalls=3 writes=4", st, wr_n - w0);
    end
    exp_q.push_back(32'hBEEFE634);
    access(1'b1, 1'b0, 3'b010, 32'h4, 32'h0, dout, st);
    e = exp_q.pop_front();
    vectors++;
    if (dout !== e) begin
      miscompares++; $display("FAIL sw@6_word4 got %h required %h", dout, e);
    end
    exp_q.push_back(32'h0000DEAD);
    access(1'b1, 1'b0, 3'b010, 32'h8, 32'h0, dout, st);
    e = exp_q.pop_front();
    vectors++;
    if (dout !== e) begin
      miscompares++; $display("FAIL sw@6_word8 got %h required %h", dout, e);
    end
  endtask

  // Interrupts a SW @6 after two bytes (mem[6], mem[7]) have been written.
  task automatic test_abort(input bit use_reset);
    logic [31:0] dout, e;
    int st;
    preload();
    MemRead = 1'b0; MemWrite = 1'b1; func3 = 3'b010; addr = 32'h6; data_in = 32'hDEADBEEF;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if (stall !== 1'b1) begin
      miscompares++; $display("FAIL abort_mid_stall got %b required 1", stall);
    end
    @(posedge clk); #1;
    if (use_reset) rst_n = 1'b0;
    else flush = 1'b1;
    @(negedge clk);
    vectors++;
    if (stall !== 1'b0 || dm_MemWrite !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_cycle reset=%0d got stall=%b wr=%b required 0 0", use_reset, stall, dm_MemWrite);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; flush = 1'b0; MemWrite = 1'b0;
    exp_q.push_back(32'hBEEFE634);
    access(1'b1, 1'b0, 3'b010, 32'h4, 32'h0, dout, st);
    e = exp_q.pop_front();
    vectors++;
    if (dout !== e || st != 0) begin
      miscompares++;
      $display("FAIL abort_word4 reset=%0d got %h stalls=%0d required %h stalls=0", use_reset, dout, st, e);
    end
    exp_q.push_back(32'h00000000);
    access(1'b1, 1'b0, 3'b010, 32'h8, 32'h0, dout, st);
    e = exp_q.pop_front();
    vectors++;
    if (dout !== e) begin
      miscompares++; $display("FAIL abort_word8 reset=%0d got %h required %h", use_reset, dout, e);
    end
  endtask
`else
  task automatic test_trap();
    logic [31:0] dout, e;
    int st, w0, n0;
    preload();
    w0 = wr_n; n0 = rd_addr.size();
    MemRead = 1'b1; MemWrite = 1'b0; func3 = 3'b010; addr = 32'h2;
    @(negedge clk);
    vectors++;
    if (misaligned_trap !== 1'b1 || dm_MemRead !== 1'b0 || stall !== 1'b0 || data_out !== 32'h0) begin
      miscompares++;
      $display("FAIL trap_lw@2 got trap=%b rd=%b stall=%b dout=%h required 1 0 0 0", misaligned_trap, dm_MemRead, stall, data_out);
    end
    @(posedge clk); #1;
    MemRead = 1'b0;
    @(negedge clk);
    vectors++;
    if (misaligned_trap !== 1'b0 || rd_addr.size() != n0) begin
      miscompares++; $display("FAIL trap_pulse got trap=%b reads=%0d required 0 0", misaligned_trap, rd_addr.size() - n0);
    end
    @(posedge clk); #1;
    access(1'b0, 1'b1, 3'b010, 32'h1, 32'hDEADBEEF, dout, st);
    exp_q.push_back(32'h030106F4);
    access(1'b1, 1'b0, 3'b010, 32'h0, 32'h0, dout, st);
    e = exp_q.pop_front();
    vectors++;
    if (dout !== e || wr_n != w0) begin
      miscompares++; $display("FAIL trap_mem got %h writes=%0d required %h writes=0", dout, wr_n - w0, e);
    end
  endtask
`endif

  initial begin
    MemRead = 1'b0; MemWrite = 1'b0; flush = 1'b0; rst_n = 1'b0;
    func3 = 3'b000; addr = '0; data_in = '0;
    test_reset();
    test_aligned();
`ifndef MISALIGNED_TRAP_EN
    test_misaligned_load();
    test_misaligned_store();
    test_abort(1'b1);
    test_abort(1'b0);
`else
    test_trap();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
